// File: rtl/dii_length_prefixer.sv
// Prepends a {LEN_TAG, length} header word to each DII packet and emits a raw 16-bit word stream.
// Optional length checking is enabled by defining DII_LENGTH_PREFIXER_CHECK_EN.

package dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module dii_length_prefixer #(
    parameter int         BUF_SIZE = 4,
    parameter logic [3:0] LEN_TAG  = 4'hA
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(BUF_SIZE):0]   packet_size,
    input  dii_pkg::dii_flit            flit_in,
    output logic                        flit_in_ready,
    output logic [15:0]                 word_out_data,
    output logic                        word_out_valid,
    input  logic                        word_out_ready,
    output logic                        len_err,
    output logic [7:0]                  len_err_cnt
);
    localparam int PSW = $clog2(BUF_SIZE) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_e;

    state_e      state_q;
    logic        out_vld_q;
    logic [15:0] out_data_q;

    logic slot_free;
    logic hdr_load;
    logic in_fire;
    logic last_fire;

    assign slot_free     = !out_vld_q || word_out_ready;
    // Ready depends only on state and the output slot, never on flit_in.
    assign flit_in_ready = (state_q == BODY) && slot_free;
    assign hdr_load      = (state_q == IDLE) && flit_in.valid && slot_free;
    assign in_fire       = flit_in.valid && flit_in_ready;
    assign last_fire     = in_fire && flit_in.last;

    assign word_out_valid = out_vld_q;
    assign word_out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_vld_q  <= 1'b0;
            out_data_q <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hdr_load) begin
                        out_vld_q  <= 1'b1;
                        out_data_q <= {LEN_TAG, 12'(packet_size)};
                        state_q    <= BODY;
                    end else if (word_out_ready) begin
                        out_vld_q <= 1'b0;
                    end
                end
                BODY: begin
                    if (in_fire) begin
                        out_vld_q  <= 1'b1;
                        out_data_q <= flit_in.data;
                        if (flit_in.last)
                            state_q <= IDLE;
                    end else if (word_out_ready) begin
                        out_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DII_LENGTH_PREFIXER_CHECK_EN
    logic [PSW-1:0] len_q;
    logic [15:0]    cnt_q;
    logic           len_err_q;
    logic [7:0]     len_err_cnt_q;
    logic [16:0]    seen_d;
    logic           mismatch;

    // Widened by one bit so the flit count can never wrap to 0 and falsely match len_q == 0.
    assign seen_d   = {1'b0, cnt_q} + 17'd1;
    assign mismatch = (seen_d != 17'(len_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            cnt_q         <= '0;
            len_err_q     <= 1'b0;
            len_err_cnt_q <= 8'h00;
        end else begin
            if (hdr_load) begin
                len_q <= packet_size;
                cnt_q <= '0;
            end else if (in_fire) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (last_fire && mismatch) begin
                len_err_q <= 1'b1;
                if (len_err_cnt_q != 8'hFF)
                    len_err_cnt_q <= len_err_cnt_q + 8'd1;
            end
        end
    end

    assign len_err     = len_err_q;
    assign len_err_cnt = len_err_cnt_q;
`else
    assign len_err     = 1'b0;
    assign len_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dii_length_prefixer.sv
// Scoreboard bench for dii_length_prefixer: a driver pushes expected words, a monitor pops and compares.
module tb_dii_length_prefixer;
    import dii_pkg::*;

    localparam int BUF_SIZE = 16;
    localparam int PSW      = $clog2(BUF_SIZE) + 1;
`ifdef DII_LENGTH_PREFIXER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PSW-1:0]  packet_size;
    dii_flit         flit_in;
    logic            flit_in_ready;
    logic [15:0]     word_out_data;
    logic            word_out_valid;
    logic            word_out_ready;
    logic            len_err;
    logic [7:0]      len_err_cnt;

    dii_length_prefixer #(.BUF_SIZE(BUF_SIZE), .LEN_TAG(4'hA)) dut (
        .clk            (clk),
        .rst            (rst),
        .packet_size    (packet_size),
        .flit_in        (flit_in),
        .flit_in_ready  (flit_in_ready),
        .word_out_data  (word_out_data),
        .word_out_valid (word_out_valid),
        .word_out_ready (word_out_ready),
        .len_err        (len_err),
        .len_err_cnt    (len_err_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic [15:0] exp_q[$];
    int          stamps[$];
    logic [15:0] pkt[$];
    bit          exp_err = 1'b0;
    int          exp_err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, so the values seen are those present at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_out_valid && word_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word: got unexpected 0x%0h, want nothing", word_out_data);
                end else begin
                    chk("word", int'(word_out_data), int'(exp_q.pop_front()));
                end
                stamps.push_back(cyc);
            end
            if (word_out_valid && !word_out_ready)
                chk("stall_ready", int'(flit_in_ready), 0);
        end
    end

    initial begin
        word_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       word_out_ready = 1'b1;
                1:       word_out_ready = ~word_out_ready;
                default: word_out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send_flit(input logic [15:0] d, input logic last);
        bit got = 1'b0;
        flit_in.valid = 1'b1;
        flit_in.last  = last;
        flit_in.data  = d;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (flit_in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        flit_in.valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL flit_accept: got timeout, want acceptance of 0x%0h", d);
        end
    endtask

    // Reference: header = tag A in the top nibble, length in the low 12 bits; then every data word.
    task automatic send_pkt(input int psize);
        int n = pkt.size();
        exp_q.push_back(16'hA000 + 16'(psize));
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        packet_size = PSW'(psize);
        for (int i = 0; i < n; i++) send_flit(pkt[i], i == n - 1);
        if (CHK && (n != psize)) begin
            exp_err = 1'b1;
            if (exp_err_cnt < 255) exp_err_cnt++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_len_err"}, int'(len_err), int'(exp_err));
        chk({tag, "_len_err_cnt"}, int'(len_err_cnt), exp_err_cnt);
    endtask

    initial begin
        flit_in     = '0;
        packet_size = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(word_out_valid), 0);
        chk("rst_data", int'(word_out_data), 0);
        chk("rst_ready", int'(flit_in_ready), 0);
        chk("rst_len_err", int'(len_err), 0);
        chk("rst_len_err_cnt", int'(len_err_cnt), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 3-flit packet, always ready: four consecutive output cycles.
        stamps.delete();
        pkt = '{16'h1111, 16'h2222, 16'h3333};
        send_pkt(3);
        drain();
        chk("t1_count", stamps.size(), 4);
        if (stamps.size() == 4) chk("t1_span", stamps[3] - stamps[0], 3);
        chk_err("t1");

        // Same packet under a toggling ready.
        ready_mode = 1;
        send_pkt(3);
        drain();
        chk_err("t2");

        // Single-flit packet immediately followed by a 2-flit packet.
        ready_mode = 0;
        @(posedge clk);
        #1;
        stamps.delete();
        pkt = '{16'hBEEF};
        send_pkt(1);
        pkt = '{16'hC0DE, 16'hF00D};
        send_pkt(2);
        drain();
        chk("t3_count", stamps.size(), 5);
        if (stamps.size() == 5) chk("t3_span", stamps[4] - stamps[0], 4);
        chk_err("t3");

        // Declared length 4, actual 2.
        pkt = '{16'h0A0A, 16'h0B0B};
        send_pkt(4);
        drain();
        chk_err("t4_first");
        for (int r = 0; r < 299; r++) begin
            ready_mode = (r % 3 == 0) ? 2 : 0;
            pkt = '{16'($urandom), 16'($urandom)};
            send_pkt(4);
        end
        ready_mode = 0;
        drain();
        chk_err("t4_sat");

        // Reset after the first of three flits has been accepted.
        exp_q.push_back(16'hA003);
        packet_size = PSW'(3);
        send_flit(16'h5555, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err     = 1'b0;
        exp_err_cnt = 0;
        chk("t5_valid", int'(word_out_valid), 0);
        chk("t5_ready", int'(flit_in_ready), 0);
        chk("t5_queue", exp_q.size(), 0);
        chk_err("t5_rst");
        pkt = '{16'h6666, 16'h7777};
        send_pkt(2);
        drain();
        chk_err("t5_after");

        // Zero packet size: header carries 0, body forwarded to last.
        pkt = '{16'h0101, 16'h0202, 16'h0303};
        send_pkt(0);
        drain();
        chk_err("t6");

        // Randomized traffic with random backpressure, gaps and occasional wrong lengths.
        ready_mode = 2;
        for (int p = 0; p < 200; p++) begin
            int n = $urandom_range(1, 8);
            int ps;
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
            ps = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : n;
            send_pkt(ps);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        chk_err("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dii_length_prefixer.md
# dii_length_prefixer

- Downstream stage of the full-packet DII buffer (`FULLPACKET != 0`).
- Consumes whole DII packets plus the buffer's `packet_size`, and emits a raw 16-bit word stream.
- Each packet goes out as one length-header word followed by the packet's data words, with no `last` sideband.
- Host-side byte/word links (UART, USB glue) use the header to re-frame packets.

## Interface
Parameters:
- `BUF_SIZE`, 4: depth of the upstream buffer.
  - `packet_size` width is `$clog2(BUF_SIZE)+1`.
  - Legal range 1..4095.
- `LEN_TAG`, 4'hA: constant placed in bits [15:12] of every header word.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `packet_size`  in  `$clog2(BUF_SIZE)+1`: flit count of the packet at the head of `flit_in`. Sampled only in IDLE.
- `flit_in`  in  `dii_flit`: upstream flit (`valid`, `last`, `data[15:0]`).
- `flit_in_ready`  out  1: upstream flit accepted when `flit_in.valid && flit_in_ready`.
- `word_out_data`  out  16: output word.
- `word_out_valid`  out  1: output word valid.
- `word_out_ready`  in  1: downstream accepts when `word_out_valid && word_out_ready`.
- `len_err`  out  1: sticky length-mismatch flag.
- `len_err_cnt`  out  8: saturating mismatch count.

## Operation
- FSM states: IDLE, BODY.
- One output register `{word_out_valid, word_out_data}`.
  - "Slot free" means `!word_out_valid || word_out_ready`.

IDLE:
- `flit_in_ready` = 0.
- When `flit_in.valid` and slot free:
  - Load output register with `{LEN_TAG, 12'(packet_size)}`.
  - Latch `packet_size` into `len_q`.
  - Clear body counter `cnt` to 0.
  - Go to BODY.
- No flit is consumed in this cycle.

BODY:
- `flit_in_ready` = slot free.
- On input fire:
  - Load output register with `flit_in.data`.
  - `cnt <= cnt + 1`.
  - If `flit_in.last`, go to IDLE.
- Otherwise, if `word_out_ready`, clear `word_out_valid`.

General:
- Output register keeps its value while `word_out_valid && !word_out_ready`.
- Load and drain in the same cycle is allowed; it gives full throughput.
- `packet_size` == 0 while `flit_in.valid` (non-full-packet source): header carries length 0, and the body is forwarded until `last`.
- Reset values: state IDLE, `word_out_valid` 0, `word_out_data` 0, `flit_in_ready` 0, `cnt` 0, `len_q` 0, `len_err` 0, `len_err_cnt` 0.
- Reset mid-packet: the partial packet is abandoned. The block restarts in IDLE and expects a fresh header-bearing packet.

## Timing
- Header word is valid 1 cycle after the first cycle with `flit_in.valid` and slot free in IDLE.
- First data flit is accepted in that same following cycle, provided `word_out_ready` was high.
- Data word latency: valid at the output 1 cycle after input fire.
- Steady-state throughput: 1 word/cycle.
- A packet of N flits occupies N+1 output cycles.
- Back-to-back packets: after the `last` fire, one IDLE cycle loads the next header. No bubble is added beyond header insertion when downstream is always ready.
- `flit_in_ready` is combinational from state, `word_out_valid` and `word_out_ready`. No combinational path from `flit_in` to `flit_in_ready`.
- `word_out_*` is driven directly from registers.

## Configuration
`DII_LENGTH_PREFIXER_CHECK_EN`, when defined:
- On the `last` fire, compares `cnt + 1` against `len_q`.
- On mismatch:
  - `len_err` is set (cleared only by `rst`).
  - `len_err_cnt` increments, saturating at 8'hFF.
- A `len_q` of 0 always counts as a mismatch.
- Data forwarding is unaffected.

When not defined:
- `len_err` and `len_err_cnt` are tied to 0.
- `cnt` and its compare logic are not built.

## Test plan
- 3-flit packet (0x1111, 0x2222, 0x3333 with `last`), `packet_size`=3, `word_out_ready`=1 → output 0xA003, 0x1111, 0x2222, 0x3333 on 4 consecutive cycles; `len_err`=0.
- Same packet with `word_out_ready` toggling 1/0 every cycle → identical word sequence, no drops or duplicates; `flit_in_ready` low whenever the output register holds an unaccepted word.
- Single-flit packet 0xBEEF (`last`), `packet_size`=1, followed immediately by a 2-flit packet → 0xA001, 0xBEEF, 0xA002, d0, d1; exactly one IDLE cycle between packets.
- With `DII_LENGTH_PREFIXER_CHECK_EN`: `packet_size`=4, but `last` on flit 2 → header 0xA004, 2 data words, `len_err`=1, `len_err_cnt`=1. Repeat 300 times → `len_err_cnt` saturates at 0xFF.
- `rst` asserted during BODY after 1 of 3 flits → next cycle `word_out_valid`=0, state IDLE. A new 2-flit packet after reset yields 0xA002 and its 2 words.
- `packet_size`=0 with `flit_in.valid` → header 0xA000, then the body is forwarded to `last`. With the check macro, `len_err`=1.
